// File: rtl/sram_like_arbiter.sv
// 2:1 SRAM-like arbiter merging the inst and data ports onto one memory port with in-order tag FIFO.
// Macros: SRAM_ARB_RR_EN (round-robin on contention), SRAM_ARB_PROTO_CHECK (sim-only response check).
module sram_like_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTSTANDING);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  logic                   lock;
  src_e                   lock_src;
  src_e                   grant_src;
  logic                   grant_req;
  logic [OUTSTANDING-1:0] tag_mem;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  src_e                   head_src;
`ifdef SRAM_ARB_RR_EN
  src_e                   rr_last;
`endif

  // A held (locked) request keeps its source until the downstream accepts it.
  always_comb begin
    grant_src = SRC_INST;
    if (lock) begin
      grant_src = lock_src;
    end else if (data_req && inst_req) begin
`ifdef SRAM_ARB_RR_EN
      grant_src = (rr_last == SRC_DATA) ? SRC_INST : SRC_DATA;
`else
      grant_src = SRC_DATA;
`endif
    end else if (data_req) begin
      grant_src = SRC_DATA;
    end
    grant_req = (grant_src == SRC_DATA) ? data_req : inst_req;
  end

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (grant_req) begin
      if (grant_src == SRC_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign mem_req    = grant_req & ~fifo_full;
  assign push       = mem_req & mem_addr_ok;
  assign pop        = mem_data_ok & ~fifo_empty;
  assign head_src   = src_e'(tag_mem[rd_ptr]);

  assign inst_addr_ok = push & (grant_src == SRC_INST);
  assign data_addr_ok = push & (grant_src == SRC_DATA);
  assign inst_data_ok = pop & (head_src == SRC_INST);
  assign data_data_ok = pop & (head_src == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock     <= 1'b0;
      lock_src <= SRC_INST;
    end else if (mem_req && !mem_addr_ok) begin
      lock     <= 1'b1;
      lock_src <= grant_src;
    end else if (push) begin
      lock <= 1'b0;
    end
  end

  // Full gating uses the registered count, so a same-cycle pop never frees a slot early.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_mem <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= grant_src;
        wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_last <= SRC_INST;
    end else if (push) begin
      rr_last <= grant_src;
    end
  end
`endif

`ifdef SRAM_ARB_PROTO_CHECK
  always_ff @(posedge clk) begin
    if (resetn && mem_data_ok && fifo_empty) begin
      $error("sram_like_arbiter: mem_data_ok with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter; expected routing follows SRAM_ARB_RR_EN.
module tb_sram_like_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [4:0]  flags;
  int          tests_run;
  int          tests_failed;

  sram_like_arbiter #(.OUTSTANDING(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  // Packed view: {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
  assign flags = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
    inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    mem_data_ok = 1;
    mem_rdata = 32'h1234;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (flags !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got %b exp %b", flags, 5'b00000);
    end
    @(negedge clk);
    idle_inputs();
    resetn = 1;
    #1;
    tests_run++;
    if (flags !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_flags got %b exp %b", flags, 5'b00000);
    end
  endtask

  task automatic test_inst_fetch();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
    #1;
    tests_run++;
    if (flags !== 5'b11000) begin
      tests_failed++;
      $display("[TB] FAIL fetch_accept got %b exp %b", flags, 5'b11000);
    end
    tests_run++;
    if (mem_addr !== 32'hBFC00000 || mem_size !== 2'd2 || mem_wr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_payload got %h/%0d/%b exp bfc00000/2/0", mem_addr, mem_size, mem_wr);
    end
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h3C080001;
    #1;
    tests_run++;
    if (flags !== 5'b00010 || inst_rdata !== 32'h3C080001) begin
      tests_failed++;
      $display("[TB] FAIL fetch_resp got %b/%h exp 00010/3c080001", flags, inst_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_priority();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_addr = 32'h200; data_wr = 1; data_wdata = 32'hAA; data_wstrb = 4'h3;
    mem_addr_ok = 1;
    #1;
    tests_run++;
    if (flags !== 5'b10100 || mem_addr !== 32'h200 || mem_wdata !== 32'hAA || mem_wstrb !== 4'h3) begin
      tests_failed++;
      $display("[TB] FAIL prio_first got %b/%h/%h/%h exp 10100/200/aa/3", flags, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    data_req = 0; data_wr = 0;
    mem_data_ok = 1; mem_rdata = 32'h11;
    #1;
    tests_run++;
    if (flags !== 5'b11001 || mem_addr !== 32'h100 || data_rdata !== 32'h11) begin
      tests_failed++;
      $display("[TB] FAIL prio_second got %b/%h/%h exp 11001/100/11", flags, mem_addr, data_rdata);
    end
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h22;
    #1;
    tests_run++;
    if (flags !== 5'b00010 || inst_rdata !== 32'h22) begin
      tests_failed++;
      $display("[TB] FAIL prio_resp got %b/%h exp 00010/22", flags, inst_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock_data();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      data_req = 1; data_addr = 32'h300;
      if (c >= 1) begin
        inst_req = 1; inst_addr = 32'h400;
      end
      mem_addr_ok = (c == 3);
      #1;
      tests_run++;
      if (flags !== ((c == 3) ? 5'b10100 : 5'b10000) || mem_addr !== 32'h300) begin
        tests_failed++;
        $display("[TB] FAIL lock_data_c%0d got %b/%h exp %b/300", c, flags, mem_addr,
                 (c == 3) ? 5'b10100 : 5'b10000);
      end
    end
    @(negedge clk);
    data_req = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h33;
    #1;
    tests_run++;
    if (flags !== 5'b11001 || mem_addr !== 32'h400) begin
      tests_failed++;
      $display("[TB] FAIL lock_data_inst got %b/%h exp 11001/400", flags, mem_addr);
    end
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h44;
    #1;
    tests_run++;
    if (flags !== 5'b00010 || inst_rdata !== 32'h44) begin
      tests_failed++;
      $display("[TB] FAIL lock_data_resp got %b/%h exp 00010/44", flags, inst_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock_inst();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'h500;
      if (c >= 1) begin
        data_req = 1; data_addr = 32'h600;
      end
      mem_addr_ok = (c == 2);
      #1;
      tests_run++;
      if (flags !== ((c == 2) ? 5'b11000 : 5'b10000) || mem_addr !== 32'h500) begin
        tests_failed++;
        $display("[TB] FAIL lock_inst_c%0d got %b/%h exp %b/500", c, flags, mem_addr,
                 (c == 2) ? 5'b11000 : 5'b10000);
      end
    end
    @(negedge clk);
    inst_req = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h55;
    #1;
    tests_run++;
    if (flags !== 5'b10110 || mem_addr !== 32'h600 || inst_rdata !== 32'h55) begin
      tests_failed++;
      $display("[TB] FAIL lock_inst_data got %b/%h/%h exp 10110/600/55", flags, mem_addr, inst_rdata);
    end
    @(negedge clk);
    idle_inputs();
    mem_data_ok = 1; mem_rdata = 32'h66;
    #1;
    tests_run++;
    if (flags !== 5'b00001 || data_rdata !== 32'h66) begin
      tests_failed++;
      $display("[TB] FAIL lock_inst_resp got %b/%h exp 00001/66", flags, data_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_full();
    logic [31:0] addrs [3];
    logic [4:0]  exp_f [4];
    addrs = '{32'h700, 32'h704, 32'h708};
    exp_f = '{5'b11000, 5'b11000, 5'b00000, 5'b00010};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = addrs[(c > 2) ? 2 : c]; mem_addr_ok = 1;
      mem_data_ok = (c == 3); mem_rdata = 32'h77;
      #1;
      tests_run++;
      if (flags !== exp_f[c]) begin
        tests_failed++;
        $display("[TB] FAIL full_c%0d got %b exp %b", c, flags, exp_f[c]);
      end
    end
    @(negedge clk);
    mem_data_ok = 0;
    #1;
    tests_run++;
    if (flags !== 5'b11000 || mem_addr !== 32'h708) begin
      tests_failed++;
      $display("[TB] FAIL full_unblock got %b/%h exp 11000/708", flags, mem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      mem_data_ok = 1; mem_rdata = 32'h78 + c;
      #1;
      tests_run++;
      if (flags !== 5'b00010 || inst_rdata !== 32'h78 + c) begin
        tests_failed++;
        $display("[TB] FAIL full_drain%0d got %b/%h exp 00010/%h", c, flags, inst_rdata, 32'h78 + c);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_spurious();
    logic [4:0] exp_f [6];
    exp_f = '{5'b00000, 5'b11000, 5'b10100, 5'b00000, 5'b00010, 5'b00001};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_inputs();
      case (c)
        0: begin mem_data_ok = 1; mem_rdata = 32'hDEAD; end
        1: begin inst_req = 1; inst_addr = 32'h800; mem_addr_ok = 1; end
        2: begin data_req = 1; data_addr = 32'h900; mem_addr_ok = 1; end
        3: begin inst_req = 1; inst_addr = 32'h804; mem_addr_ok = 1; end
        default: begin mem_data_ok = 1; mem_rdata = 32'h80 + c; end
      endcase
      #1;
      tests_run++;
      if (flags !== exp_f[c]) begin
        tests_failed++;
        $display("[TB] FAIL spurious_c%0d got %b exp %b", c, flags, exp_f[c]);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic prev_d;
    logic exp_d;
    logic [4:0] exp_f;
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    prev_d = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inst_req = 1; inst_addr = 32'hA00;
      data_req = 1; data_addr = 32'hB00;
      mem_addr_ok = 1; mem_data_ok = (k > 0); mem_rdata = k;
`ifdef SRAM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      exp_f = {1'b1, ~exp_d, exp_d, (k > 0) & ~prev_d, (k > 0) & prev_d};
      #1;
      tests_run++;
      if (flags !== exp_f || mem_addr !== (exp_d ? 32'hB00 : 32'hA00)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_k%0d got %b/%h exp %b/%h", k, flags, mem_addr, exp_f,
                 exp_d ? 32'hB00 : 32'hA00);
      end
      prev_d = exp_d;
    end
    @(negedge clk);
    resetn = 0;
    idle_inputs();
    mem_data_ok = 1;
    #1;
    tests_run++;
    if (flags !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL b2b_reset got %b exp %b", flags, 5'b00000);
    end
    @(negedge clk);
    resetn = 1;
    mem_data_ok = 1;
    #1;
    tests_run++;
    if (flags !== 5'b00000) begin
      tests_failed++;
      $display("[TB] FAIL b2b_after_reset got %b exp %b", flags, 5'b00000);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      inst_req = 1; inst_addr = 32'hC00 + c; mem_addr_ok = 1;
      #1;
      tests_run++;
      if (flags !== ((c < 2) ? 5'b11000 : 5'b00000)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_count_c%0d got %b exp %b", c, flags, (c < 2) ? 5'b11000 : 5'b00000);
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    resetn = 0;
    idle_inputs();
    test_reset();
    test_inst_fetch();
    test_priority();
    test_lock_data();
    test_lock_inst();
    test_full();
    test_spurious();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
